// File: rtl/calc_sequencer_if.sv
// Instruction handshake between the keypad/instruction front end and calc_sequencer.
interface calc_sequencer_if;
  logic       InValid;
  logic       InReady;
  logic [2:0] OP;
  logic [1:0] K;

  modport master (output InValid, output OP, output K, input InReady);
  modport slave  (input InValid, input OP, input K, output InReady);
endinterface

// File: rtl/calc_sequencer.sv
// Calculator controller: four 5-bit registers, single-cycle ops and a 5-cycle
// shift-add multiply, sequenced IDLE -> EXEC/MUL -> DONE -> IDLE.
module calc_sequencer (
  input  logic              Clock,
  input  logic              Reset,
  calc_sequencer_if.slave   bus,
  output logic              Busy,
  output logic              Done,
  output logic              Overflow,
  output logic [4:0]        R0,
  output logic [4:0]        R1,
  output logic [4:0]        R2,
  output logic [4:0]        R3
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
  typedef enum logic [2:0] {
    OP_INIT, OP_LDI, OP_MOVE, OP_STORE, OP_ADD, OP_SUB, OP_MUL, OP_POW2
  } op_t;

  state_t     state, state_d;
  op_t        op_q;
  logic [1:0] k_q;
  logic [4:0] a_q, b_q;
  logic [4:0] rf    [4];
  logic [4:0] rf_nx [4];
  logic       ov, ov_nx, wb;
  logic [9:0] acc, mcand, acc_nx;
  logic [4:0] mplier;
  logic [2:0] cnt;
  logic [5:0] sum6;
  logic       accept;

  assign bus.InReady = (state == IDLE) && !Reset;
  assign accept      = bus.InValid && bus.InReady;
  assign Busy        = (state != IDLE);
  assign Done        = (state == DONE);
  assign Overflow    = ov;
  assign R0          = rf[0];
  assign R1          = rf[1];
  assign R2          = rf[2];
  assign R3          = rf[3];

  assign sum6   = {1'b0, a_q} + {1'b0, b_q};
  assign acc_nx = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = (op_t'(bus.OP) == OP_MUL) ? MUL : EXEC;
      EXEC:    state_d = DONE;
      MUL:     if (cnt == 3'd4) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writeback values; the last multiply step folds its add directly into R0.
  always_comb begin
    rf_nx = rf;
    ov_nx = ov;
    wb    = 1'b0;
    if (state == MUL && cnt == 3'd4) begin
      wb       = 1'b1;
      rf_nx[0] = acc_nx[4:0];
      ov_nx    = |acc_nx[9:5];
    end else if (state == EXEC) begin
      wb    = 1'b1;
      ov_nx = 1'b0;
      case (op_q)
        OP_INIT: begin
          rf_nx[0] = 5'd0;
          rf_nx[1] = 5'd1;
          rf_nx[2] = 5'd2;
          rf_nx[3] = 5'd3;
        end
        OP_LDI:   rf_nx[0]   = {3'b0, k_q};
        OP_MOVE:  rf_nx[0]   = b_q;
        OP_STORE: rf_nx[k_q] = a_q;
        OP_ADD: begin
          rf_nx[0] = sum6[4:0];
          ov_nx    = sum6[5];
        end
        OP_SUB: begin
          rf_nx[0] = a_q - b_q;
          ov_nx    = (a_q < b_q);
        end
        OP_POW2: begin
          if (b_q < 5'd5) begin
            rf_nx[0] = 5'd1 << b_q;
          end else begin
            rf_nx[0] = 5'd0;
            ov_nx    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      rf     <= '{5'd0, 5'd1, 5'd2, 5'd3};
      ov     <= 1'b0;
      op_q   <= OP_INIT;
      k_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        op_q   <= op_t'(bus.OP);
        k_q    <= bus.K;
        a_q    <= rf[0];
        b_q    <= rf[bus.K];
        acc    <= '0;
        mcand  <= {5'b0, rf[0]};
        mplier <= rf[bus.K];
        cnt    <= '0;
      end else if (state == MUL) begin
        acc    <= acc_nx;
        mcand  <= {mcand[8:0], 1'b0};
        mplier <= {1'b0, mplier[4:1]};
        cnt    <= cnt + 3'd1;
      end
      if (wb) begin
        rf <= rf_nx;
        ov <= ov_nx;
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: instruction-level model compared every
// cycle, plus literal expectations for the directed sequences.
module tb_calc_sequencer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Busy, Done, Overflow;
  logic [4:0] R0, R1, R2, R3;

  calc_sequencer_if bus ();

  calc_sequencer dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .bus      (bus),
    .Busy     (Busy),
    .Done     (Done),
    .Overflow (Overflow),
    .R0       (R0),
    .R1       (R1),
    .R2       (R2),
    .R3       (R3)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Instruction-level model: an accepted instruction becomes visible after a
  // fixed latency (1 or 5 cycles), then one DONE cycle, then idle.
  int m_r [4];
  int p_r [4];
  int m_ov, p_ov, m_c, m_lat;
  bit m_active = 0, m_acc = 0, m_valid = 0;

  always @(posedge Clock) begin
    int a, b, s;
    m_acc = 0;
    if (Reset) begin
      m_r      = '{0, 1, 2, 3};
      m_ov     = 0;
      m_active = 0;
      m_valid  = 1;
    end else if (m_valid) begin
      if (m_active) begin
        m_c++;
        if (m_c == m_lat) begin
          m_r  = p_r;
          m_ov = p_ov;
        end
        if (m_c == m_lat + 1) m_active = 0;
      end else if (bus.InValid === 1'b1) begin
        a     = m_r[0];
        b     = m_r[bus.K];
        p_r   = m_r;
        p_ov  = 0;
        m_lat = 1;
        case (bus.OP)
          3'd0: p_r = '{0, 1, 2, 3};
          3'd1: p_r[0] = int'(bus.K);
          3'd2: p_r[0] = b;
          3'd3: p_r[bus.K] = a;
          3'd4: begin s = a + b; p_r[0] = s % 32; p_ov = (s > 31); end
          3'd5: begin p_r[0] = (a - b + 32) % 32; p_ov = (a < b); end
          3'd6: begin s = a * b; p_r[0] = s % 32; p_ov = (s > 31); m_lat = 5; end
          default: begin
            if (b < 5) p_r[0] = 1 << b;
            else begin p_r[0] = 0; p_ov = 1; end
          end
        endcase
        m_active = 1;
        m_c      = 0;
        m_acc    = 1;
      end
    end
  end

  always @(negedge Clock) begin
    if (m_valid) begin
      chk("R0", R0, m_r[0]);
      chk("R1", R1, m_r[1]);
      chk("R2", R2, m_r[2]);
      chk("R3", R3, m_r[3]);
      chk("Overflow", Overflow, m_ov);
      chk("Busy", Busy, m_active);
      chk("Done", Done, (m_active && m_c == m_lat));
      chk("InReady", bus.InReady, (!m_active && !Reset));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (m_active && n < 20) begin
      @(posedge Clock); #2;
      n++;
    end
    if (m_active) chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] k);
    bit got = 0;
    bus.InValid = 1'b1;
    bus.OP      = op;
    bus.K       = k;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge Clock); #1;
      got = m_acc;
    end
    if (!got) chk("accept_timeout", 0, 1);
    #1;
    bus.InValid = 1'b0;
    bus.OP      = 3'($urandom);
    bus.K       = 2'($urandom);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset       = 1'b1;
    bus.InValid = 1'b0;
    bus.OP      = '0;
    bus.K       = '0;
    repeat (3) @(posedge Clock);
    #2 Reset = 1'b0;
    #1;
    chk("lit_reset_R0", R0, 0);
    chk("lit_reset_R1", R1, 1);
    chk("lit_reset_R2", R2, 2);
    chk("lit_reset_R3", R3, 3);
    chk("lit_reset_ov", Overflow, 0);
    chk("lit_reset_ready", bus.InReady, 1);
    chk("lit_reset_done", Done, 0);
    #1;

    issue(3'd1, 2'd3);              // LDI 3
    issue(3'd4, 2'd2);              // ADD R2 -> 5
    chk("lit_add", R0, 5);
    chk("lit_add_ov", Overflow, 0);

    issue(3'd1, 2'd3);              // LDI 3
    issue(3'd3, 2'd1);              // STORE R1
    for (int i = 0; i < 9; i++) issue(3'd4, 2'd1);
    chk("lit_add30", R0, 30);
    chk("lit_add30_ov", Overflow, 0);
    issue(3'd4, 2'd1);
    chk("lit_wrap", R0, 1);
    chk("lit_wrap_ov", Overflow, 1);

    issue(3'd1, 2'd3);
    issue(3'd4, 2'd3);              // 3+3 = 6
    issue(3'd3, 2'd1);              // R1 = 6
    issue(3'd1, 2'd3);
    issue(3'd4, 2'd2);              // 3+2 = 5
    issue(3'd6, 2'd1);              // 5*6
    chk("lit_mul30", R0, 30);
    chk("lit_mul30_ov", Overflow, 0);

    issue(3'd1, 2'd3);
    issue(3'd4, 2'd1);              // 3+6? R1=6 -> 9; rebuild 7 below
    issue(3'd1, 2'd3);
    issue(3'd4, 2'd0);              // 6
    issue(3'd3, 2'd1);              // R1 = 6
    issue(3'd1, 2'd1);
    issue(3'd4, 2'd1);              // 7
    issue(3'd3, 2'd1);              // R1 = 7
    issue(3'd6, 2'd1);              // 7*7 = 49
    chk("lit_mul49", R0, 17);
    chk("lit_mul49_ov", Overflow, 1);

    issue(3'd1, 2'd3);
    issue(3'd3, 2'd2);              // R2 = 3
    issue(3'd7, 2'd2);
    chk("lit_pow8", R0, 8);
    chk("lit_pow8_ov", Overflow, 0);
    issue(3'd1, 2'd3);
    issue(3'd4, 2'd0);              // 6
    issue(3'd3, 2'd2);              // R2 = 6
    issue(3'd7, 2'd2);
    chk("lit_pow6", R0, 0);
    chk("lit_pow6_ov", Overflow, 1);

    issue(3'd1, 2'd3);
    issue(3'd3, 2'd3);              // R3 = 3
    issue(3'd1, 2'd2);
    issue(3'd5, 2'd3);              // 2-3
    chk("lit_sub", R0, 31);
    chk("lit_sub_ov", Overflow, 1);

    issue(3'd2, 2'd2);              // MOVE R2
    issue(3'd3, 2'd0);              // STORE K=0
    issue(3'd7, 2'd0);              // POW2 of R0=6
    issue(3'd0, 2'd1);              // INIT
    chk("lit_init_R3", R3, 3);

    bus.InValid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bus.OP = 3'($urandom_range(0, 7));
      bus.K  = 2'($urandom);
      @(posedge Clock); #2;
    end
    bus.InValid = 1'b0;
    wait_idle();

    issue(3'd1, 2'd3);
    issue(3'd3, 2'd1);              // R1 = 3
    bus.InValid = 1'b1;
    bus.OP      = 3'd6;
    bus.K       = 2'd1;
    begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(posedge Clock); #1;
        got = m_acc;
      end
      if (!got) chk("mul_accept_timeout", 0, 1);
    end
    bus.InValid = 1'b0;
    @(posedge Clock);
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    chk("lit_rst_mul_R0", R0, 0);
    chk("lit_rst_mul_R1", R1, 1);
    chk("lit_rst_mul_busy", Busy, 0);
    #1;
    issue(3'd1, 2'd2);
    chk("lit_after_rst", R0, 2);

    repeat (2) @(posedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
